instr_mem_loader: RTL and testbench



---
 rtl/instr_mem_pkg.sv | 22 ++
 rtl/instr_mem_ram.sv | 46 ++++
 rtl/instr_mem_loader.sv | 132 +++++++++++++
 tb/tb_instr_mem_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// ============================================================================
// Module : instr_mem_pkg
// Brief  : Shared loader state encoding and default geometry / fill word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_mem_pkg;

    localparam int DEF_INSTR_WIDTH = 9;
    localparam int DEF_ADDR_WIDTH  = 8;
    localparam logic [31:0] DEF_FILL_INSTR = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_mem_ram.sv
// ============================================================================
// Module : instr_mem_ram
// Brief  : Simple dual-port RAM, one write port and one registered read port.
//          The caller widens WIDTH by one when IMEM_PARITY_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_mem_ram
    import instr_mem_pkg::*;
#(
    parameter int WIDTH      = DEF_INSTR_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] mem [DEPTH];

    // Array is deliberately left unreset; only the read register clears.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_mem_loader.sv
// ============================================================================
// Module : instr_mem_loader
// Brief  : Streams a program into instruction RAM, then serves 1-cycle fetches.
//          Optional macro IMEM_PARITY_EN adds a stored even-parity bit and
//          the parity_err output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int                     INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int                     ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter logic [INSTR_WIDTH-1:0] FILL_INSTR  = INSTR_WIDTH'(DEF_FILL_INSTR)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_start,
    input  logic                   load_valid,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   load_last,
    output logic                   load_ready,
    output logic                   load_done,
    output logic [ADDR_WIDTH:0]    prog_len,
    input  logic                   fetch_req,
    input  logic [ADDR_WIDTH-1:0]  fetch_addr,
    output logic                   fetch_ready,
    output logic                   fetch_valid,
    output logic [INSTR_WIDTH-1:0] fetch_instr
`ifdef IMEM_PARITY_EN
    ,
    output logic                   parity_err
`endif
);

`ifdef IMEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int MEM_W = INSTR_WIDTH + PAR_W;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic                  r_fill;
    logic                  w_beat;
    logic                  w_fetch;
    logic                  w_last_slot;
    logic [MEM_W-1:0]      w_wr_data;
    logic [MEM_W-1:0]      w_rd_data;

    // A load_start in the same cycle wins over the beat.
    assign w_beat      = load_valid && load_ready && !load_start;
    assign w_fetch     = fetch_req && fetch_ready;
    assign w_last_slot = (r_wr_ptr == {ADDR_WIDTH{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (load_start) w_next = ST_LOAD;
            ST_LOAD: if (!load_start && w_beat && (load_last || w_last_slot)) w_next = ST_RUN;
            ST_RUN:  if (load_start) w_next = ST_LOAD;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        load_ready  = (r_state == ST_LOAD);
        fetch_ready = (r_state == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            prog_len    <= '0;
            load_done   <= 1'b0;
            fetch_valid <= 1'b0;
            r_fill      <= 1'b0;
        end else begin
            if (load_start) begin
                r_wr_ptr <= '0;
                prog_len <= '0;
            end else if (w_beat) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
                prog_len <= prog_len + (ADDR_WIDTH + 1)'(1);
            end
            load_done   <= (r_state == ST_LOAD) && (w_next == ST_RUN);
            fetch_valid <= w_fetch;
            if (w_fetch) begin
                r_fill <= ({1'b0, fetch_addr} >= prog_len);
            end
        end
    end

`ifdef IMEM_PARITY_EN
    assign w_wr_data  = {^load_data, load_data};
    assign parity_err = fetch_valid && !r_fill && (^w_rd_data);
`else
    assign w_wr_data  = load_data;
`endif

    // Both r_fill and the RAM read register only move on an accepted fetch,
    // so the output holds between fetches.
    assign fetch_instr = r_fill ? FILL_INSTR : w_rd_data[INSTR_WIDTH-1:0];

    instr_mem_ram #(
        .WIDTH      (MEM_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_beat),
        .wr_addr (r_wr_ptr),
        .wr_data (w_wr_data),
        .rd_en   (w_fetch),
        .rd_addr (fetch_addr),
        .rd_data (w_rd_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// ============================================================================
// Module : tb_instr_mem_loader
// Brief  : Scoreboard bench for instr_mem_loader (IMEM_PARITY_EN optional).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_mem_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [8:0] load_data = '0;
    logic       load_last = 1'b0;
    logic       load_ready;
    logic       load_done;
    logic [8:0] prog_len;
    logic       fetch_req = 1'b0;
    logic [7:0] fetch_addr = '0;
    logic       fetch_ready;
    logic       fetch_valid;
    logic [8:0] fetch_instr;
`ifdef IMEM_PARITY_EN
    logic       parity_err;
`endif

    typedef struct {
        logic [8:0] data;
        logic       perr;
        int         due;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    instr_mem_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .prog_len    (prog_len),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr)
`ifdef IMEM_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per fetch_valid and checks data and latency.
    always @(negedge clk) begin
        if (load_done) done_cnt++;
        if (fetch_valid) begin
            if (q.size() == 0) begin
                check("unexpected_fetch_valid", 1, 0);
            end else begin
                check("fetch_instr", int'(fetch_instr), int'(q[0].data));
                check("fetch_latency_cycle", cyc, q[0].due);
`ifdef IMEM_PARITY_EN
                check("parity_err", int'(parity_err), int'(q[0].perr));
`endif
                void'(q.pop_front());
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            check("missing_fetch_valid_due", cyc, q[0].due - 1);
            void'(q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic beat(input logic [8:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] a, input logic [8:0] d, input logic pe);
        exp_t e;
        fetch_req  = 1'b1;
        fetch_addr = a;
        e.data = d;
        e.perr = pe;
        e.due  = cyc + 1;
        q.push_back(e);
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic drain();
        repeat (3) tick();
        check("scoreboard_empty", q.size(), 0);
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_load_ready", int'(load_ready), 0);
        check("rst_load_done", int'(load_done), 0);
        check("rst_fetch_ready", int'(fetch_ready), 0);
        check("rst_fetch_valid", int'(fetch_valid), 0);
        check("rst_fetch_instr", int'(fetch_instr), 0);
        check("rst_prog_len", int'(prog_len), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fetch requests in IDLE are ignored (monitor flags any valid)
        fetch_req = 1'b1;
        repeat (3) tick();
        fetch_req = 1'b0;

        // Three-word program, back-to-back fetches incl. one past the end
        done_cnt = 0;
        start_load();
        check("load_ready_in_load", int'(load_ready), 1);
        beat(9'h14F, 1'b0);
        beat(9'h16F, 1'b0);
        beat(9'h0B1, 1'b1);
        tick();
        check("load_done_pulses_3w", done_cnt, 1);
        check("prog_len_3w", int'(prog_len), 3);
        check("fetch_ready_run", int'(fetch_ready), 1);
        fetch(8'd0, 9'h14F, 1'b0);
        fetch(8'd1, 9'h16F, 1'b0);
        fetch(8'd2, 9'h0B1, 1'b0);
        fetch(8'd3, 9'h000, 1'b0);
        drain();
        check("fetch_instr_hold", int'(fetch_instr), 0);

        // Fetches in LOAD ignored; load_start mid-load drops its beat
        start_load();
        fetch_req = 1'b1;
        beat(9'h001, 1'b0);
        beat(9'h002, 1'b0);
        beat(9'h003, 1'b0);
        beat(9'h004, 1'b0);
        fetch_req = 1'b0;
        check("prog_len_4_beats", int'(prog_len), 4);
        load_start = 1'b1;
        beat(9'h111, 1'b0);
        load_start = 1'b0;
        check("prog_len_after_restart", int'(prog_len), 0);
        check("still_loading", int'(load_ready), 1);
        done_cnt = 0;
        beat(9'h0AA, 1'b0);
        beat(9'h155, 1'b1);
        tick();
        check("prog_len_reload_2w", int'(prog_len), 2);
        check("load_done_reload", done_cnt, 1);
        fetch(8'd0, 9'h0AA, 1'b0);
        fetch(8'd1, 9'h155, 1'b0);
        fetch(8'd2, 9'h000, 1'b0);
        drain();

        // Full-depth load without load_last
        done_cnt = 0;
        start_load();
        for (int i = 0; i < 256; i++) begin
            beat(9'(i), 1'b0);
        end
        tick();
        check("prog_len_full", int'(prog_len), 256);
        check("load_done_full", done_cnt, 1);
        check("run_after_full", int'(fetch_ready), 1);
        fetch(8'hFF, 9'h0FF, 1'b0);
        fetch(8'h00, 9'h000, 1'b0);
        fetch(8'h80, 9'h080, 1'b0);
        drain();

        // Reset mid-load abandons the load
        done_cnt = 0;
        start_load();
        beat(9'h101, 1'b0);
        beat(9'h102, 1'b0);
        rst_n = 1'b0;
        #2;
        check("midrst_prog_len", int'(prog_len), 0);
        check("midrst_load_ready", int'(load_ready), 0);
        check("midrst_fetch_ready", int'(fetch_ready), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_no_load_done", done_cnt, 0);
        start_load();
        beat(9'h1AA, 1'b1);
        tick();
        check("prog_len_1w", int'(prog_len), 1);
        fetch(8'd1, 9'h000, 1'b0);
        fetch(8'd0, 9'h1AA, 1'b0);
        drain();

`ifdef IMEM_PARITY_EN
        start_load();
        beat(9'h0F0, 1'b0);
        beat(9'h033, 1'b1);
        tick();
        dut.u_ram.mem[0] = dut.u_ram.mem[0] ^ 10'h001;
        fetch(8'd0, 9'h0F1, 1'b1);
        fetch(8'd1, 9'h033, 1'b0);
        fetch(8'd2, 9'h000, 1'b0);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
